vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33; vertical porches and sync in lines.
REQ-007 Parameter SYNC_POL, default 0, sync asserted level (0 = active-low).
REQ-008 Parameter COLOR_W, default 4, bits per colour channel.
REQ-009 Parameter PIX_DIV, default 2, clk cycles per pixel tick (range 1..16).
REQ-010 clk  input  1  system clock.
REQ-011 rst_n  input  1  asynchronous active-low reset.
REQ-012 en  input  1  run enable; 0 freezes all counters and outputs.
REQ-013 pix_rgb  input  3*COLOR_W  renderer colour for the current x/y, {r,g,b}.
REQ-014 x, y  output  10 each  active-area coordinates of the pixel being requested.
REQ-015 req  output  1  high while x/y lie inside the active area.
REQ-016 hor_sync, ver_sync  output  1 each  sync pulses at level SYNC_POL.
REQ-017 red, green, blue  output  COLOR_W each  pixel colour, zero outside the active area.
REQ-018 de  output  1  data enable, aligned with red/green/blue.
REQ-019 frame_start  output  1  one-clk pulse at the first pixel tick of each frame.

Function
REQ-020 Pixel tick: a divider counts 0..PIX_DIV-1 and issues a tick when it reaches PIX_DIV-1; with PIX_DIV=1 every clk is a tick.
REQ-021 h_cnt counts 0..H_TOTAL-1 on each tick (H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP) and wraps to 0.
REQ-022 v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0 on the same tick that h_cnt wraps.
REQ-023 Line order: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch; vertical order is the same.
REQ-024 req = h_cnt and v_cnt both in their active windows (combinational from the counters); x = h_cnt-(H_SYNC+H_BP), y = v_cnt-(V_SYNC+V_BP) when req=1, otherwise 0.
REQ-025 Output stage registered on the tick: hor_sync, ver_sync, de and colour are all one pixel tick after the corresponding counter value, so pix_rgb sampled at the tick lines up with the syncs.
REQ-026 Sync asserted (= SYNC_POL) while h_cnt < H_SYNC (resp. v_cnt < V_SYNC); deasserted (= ~SYNC_POL) otherwise.
REQ-027 red/green/blue = pix_rgb fields when req=1 at the tick, otherwise 0; de = registered req.
REQ-028 frame_start = 1 for exactly one clk, on the tick where h_cnt=0 and v_cnt=0.
REQ-029 en=0 holds the divider, counters and output registers; no frame_start is issued; resuming continues from the held state.
REQ-030 Counter widths are fixed at 10 bits; H_TOTAL and V_TOTAL must each be ≤1024 (elaboration-time check).

Reset
REQ-031 rst_n low asynchronously clears the divider, h_cnt, v_cnt, red/green/blue, de and frame_start, and drives hor_sync and ver_sync to ~SYNC_POL.
REQ-032 Reset asserted mid-frame aborts the frame; after release the first tick restarts at h_cnt=0, v_cnt=0 with a frame_start pulse.

Structure
REQ-033 A shared package vga_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL functions and the COLOR_W default.
REQ-034 One sub-module, vga_axis_counter (parametrised total, tick in, count out, wrap out), is instantiated twice: once horizontal and once vertical.

Verification
REQ-035 Defaults, en=1, reset released -> hor_sync low for 96 ticks, period 800 ticks (1600 clk), ver_sync low for 2 lines, frame period 525 lines.
REQ-036 pix_rgb = 12'hF0A constant -> red=F, green=0, blue=A with de=1 from output h 144..783 and v 35..514; all zero elsewhere.
REQ-037 Ramp check -> req first goes high at h_cnt=144, v_cnt=35 with x=0, y=0; last req has x=639, y=479.
REQ-038 PIX_DIV=1, SYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> line of 14 clk, frame of 98 clk, sync high-true, frame_start every 98 clk.
REQ-039 en dropped for 37 clk mid-line -> all outputs frozen; after resume the line completes with total length 800 ticks + 37 clk.
REQ-040 rst_n pulsed low at v_cnt=200 -> outputs take reset values immediately; frame_start 1 tick after release; next frame is full length.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and helpers: default 640x480@60 timing, counter
// width and the per-axis total derivation used by the timing generator.
package vga_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_COLOR_W = 4;
  localparam int DEF_PIX_DIV = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Total length of one axis (line in pixels or frame in lines).
  function automatic int axis_total(int sync, int bp, int active, int fp);
    return sync + bp + active + fp;
  endfunction

  function automatic int h_total(int sync, int bp, int active, int fp);
    return axis_total(sync, bp, active, fp);
  endfunction

  function automatic int v_total(int sync, int bp, int active, int fp);
    return axis_total(sync, bp, active, fp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; advances on tick_i and
// flags the tick on which it wraps back to zero.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);

  cnt_t cnt_q, cnt_d;

  assign wrap_o = tick_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + cnt_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, horizontal/vertical position
// counters and a tick-registered output stage aligning colour with the syncs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int PIX_DIV  = DEF_PIX_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 req,
  output logic                 hor_sync,
  output logic                 ver_sync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 de,
  output logic                 frame_start
);

  localparam int H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be within 1..16");
  end

  // Active windows use inclusive last positions so a zero front porch at a
  // 1024 total still fits in the 10-bit compare.
  localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_FIRST = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_LAST  = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam cnt_t V_ACT_FIRST = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_LAST  = cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0] div_q, div_d;
  logic       tick;
  cnt_t       h_cnt, v_cnt;
  logic       h_wrap, v_wrap;
  logic       h_act, v_act;

  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 de_q, de_d;
  logic                 fs_q, fs_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  assign tick = en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = tick ? '0 : div_q + 4'd1;
    end
  end

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap)
  );

  // The end of a frame must always land the raster back on the origin.
  a_frame_wrap_origin : assert property (@(posedge clk) disable iff (!rst_n)
    v_wrap |=> (h_cnt == '0 && v_cnt == '0));

  assign h_act = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST);
  assign v_act = (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
  assign req   = h_act && v_act;
  assign x     = req ? h_cnt - H_ACT_FIRST : '0;
  assign y     = req ? v_cnt - V_ACT_FIRST : '0;

  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    rgb_d = rgb_q;
    fs_d  = 1'b0;
    if (tick) begin
      hs_d  = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vs_d  = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      de_d  = req;
      rgb_d = req ? pix_rgb : '0;
      fs_d  = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
    end
  end

  assign hor_sync    = hs_q;
  assign ver_sync    = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];

endmodule
